// File: rtl/alu_arith_scheduler_pkg.sv
// Shared definitions for the arithmetic-unit scheduler: op codes, FSM encoding
// and the default datapath width used by both the scheduler and the unit.
package alu_arith_scheduler_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_arith_scheduler_if.sv
// Bundle of the two request channels, the tagged response channel and the
// arithmetic-unit side signals of the scheduler.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its payload stable
// while valid is high and ready is low.
interface alu_arith_scheduler_if
  import alu_arith_scheduler_pkg::*;
#(
  parameter int width = ALU_WIDTH
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [width-1:0] req0_a;
  logic [width-1:0] req0_b;
  logic [1:0]       req0_fun;

  logic             req1_valid;
  logic             req1_ready;
  logic [width-1:0] req1_a;
  logic [width-1:0] req1_b;
  logic [1:0]       req1_fun;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [width-1:0] resp_data;
  logic             resp_carry;
  logic             resp_err;

  logic [width-1:0] alu_a;
  logic [width-1:0] alu_b;
  logic [1:0]       alu_fun;
  logic             alu_en;
  logic [width-1:0] alu_out;
  logic             alu_carry;
  logic             alu_flag;

  // Environment side: requesters, response consumer and the arithmetic unit.
  modport master (
    output req0_valid, req0_a, req0_b, req0_fun,
    output req1_valid, req1_a, req1_b, req1_fun,
    output resp_ready, alu_out, alu_carry, alu_flag,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_carry, resp_err,
    input  alu_a, alu_b, alu_fun, alu_en
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun,
    input  req1_valid, req1_a, req1_b, req1_fun,
    input  resp_ready, alu_out, alu_carry, alu_flag,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_carry, resp_err,
    output alu_a, alu_b, alu_fun, alu_en
  );

endinterface

// File: rtl/alu_arith_scheduler_arbiter.sv
// Two-way round-robin grant. The last-grant pointer moves only when a grant
// is actually issued, so requester 0 wins the first tie after reset.
module alu_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  logic r_last;

  // On a tie the requester that did not win last time is served.
  assign o_grant[0] = i_enable & i_valid[0] & (~i_valid[1] | r_last);
  assign o_grant[1] = i_enable & i_valid[1] & (~i_valid[0] | ~r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_arith_scheduler.sv
// Shares one registered-latency arithmetic unit between two requesters:
// round-robin accept, single enable pulse, result capture, tagged response.
module alu_arith_scheduler
  import alu_arith_scheduler_pkg::*;
#(
  parameter int width   = ALU_WIDTH,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_arith_scheduler_if.slave bus,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           r_state;
  state_e           w_next;
  logic [width-1:0] r_a;
  logic [width-1:0] r_b;
  logic [1:0]       r_fun;
  logic             r_id;
  logic [TW-1:0]    r_timer;
  logic [width-1:0] r_resp_data;
  logic             r_resp_carry;
  logic             r_resp_err;

  logic [1:0]       w_grant;
  logic             w_idle;
  logic             w_accept;
  logic             w_sel_id;
  logic [width-1:0] w_sel_a;
  logic [width-1:0] w_sel_b;
  logic [1:0]       w_sel_fun;
  logic             w_div_zero;
  logic             w_timeout;

  assign w_idle = (r_state == S_IDLE);

  alu_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  ({bus.req1_valid, bus.req0_valid}),
    .i_enable (w_idle),
    .o_grant  (w_grant)
  );

  assign w_accept   = |w_grant;
  assign w_sel_id   = w_grant[1];
  assign w_sel_a    = w_sel_id ? bus.req1_a   : bus.req0_a;
  assign w_sel_b    = w_sel_id ? bus.req1_b   : bus.req0_b;
  assign w_sel_fun  = w_sel_id ? bus.req1_fun : bus.req0_fun;
  assign w_div_zero = (w_sel_fun == OP_DIV) && (w_sel_b == '0);
  // Last waiting cycle: the timer would reach TIMEOUT on this edge.
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_div_zero ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (bus.alu_flag || w_timeout) w_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_fun        <= '0;
      r_id         <= 1'b0;
      r_timer      <= '0;
      r_resp_data  <= '0;
      r_resp_carry <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_fun <= w_sel_fun;
            r_id  <= w_sel_id;
            // Divide-by-zero is answered without touching the unit.
            if (w_div_zero) begin
              r_resp_data  <= '0;
              r_resp_carry <= 1'b0;
              r_resp_err   <= 1'b1;
            end
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          if (bus.alu_flag) begin
            r_resp_data  <= bus.alu_out;
            r_resp_carry <= bus.alu_carry;
            r_resp_err   <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
            if (w_timeout) begin
              r_resp_data  <= '0;
              r_resp_carry <= 1'b0;
              r_resp_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];

  assign bus.alu_en  = (r_state == S_ISSUE);
  assign bus.alu_a   = w_idle ? '0 : r_a;
  assign bus.alu_b   = w_idle ? '0 : r_b;
  assign bus.alu_fun = w_idle ? '0 : r_fun;

  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_id    = r_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_carry = r_resp_carry;
  assign bus.resp_err   = r_resp_err;

  assign busy      = ~w_idle;
  assign dbg_state = r_state;

endmodule
